// File: rtl/led_blink_pkg.sv
// Shared types and width helpers for the LED blink driver.
package led_blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int unsigned PEND_W_DEF = 4;
    localparam int unsigned COUNT_W    = 4;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_PER_TICK enabled cycles.
module tick_gen
    import led_blink_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned     PS_W   = cnt_w(CLK_PER_TICK);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_PER_TICK - 1);

    logic [PS_W-1:0] prescaler;

    assign tick_c = en && (prescaler == PS_MAX);

    // Clear wins over counting so every state entry starts a full tick period.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= tick_c ? '0 : prescaler + PS_W'(1);
        end
    end

endmodule

// File: rtl/led_blink_driver.sv
// Turns event pulses into timed LED blink bursts; requests accumulate in a
// saturating pending counter and are played back without loss.
module led_blink_driver
    import led_blink_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 25000,
    parameter int unsigned ON_TICKS     = 100,
    parameter int unsigned OFF_TICKS    = 100,
    parameter int unsigned PEND_W       = PEND_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig,
    input  logic [COUNT_W-1:0] count,
    output logic               led,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    localparam int unsigned       PH_W     = cnt_w(max_u(ON_TICKS, OFF_TICKS));
    localparam logic [PH_W-1:0]   ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0]   OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam int unsigned       SUM_W    = max_u(PEND_W, COUNT_W) + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    state_t            state_next;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_next;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_next;
    logic [SUM_W-1:0]  add;
    logic [SUM_W-1:0]  sum;
    logic              entry;
    logic              dec;
    logic              led_next;
    logic              done_next;
    logic              ovf_next;
    logic              tick_c;

    tick_gen #(
        .CLK_PER_TICK (CLK_PER_TICK)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (state != IDLE),
        .clr    (entry),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = ON;
                end
            end
            ON: begin
                if (tick_c && (phase == ON_LAST)) begin
                    state_next = OFF;
                end
            end
            OFF: begin
                if (tick_c && (phase == OFF_LAST)) begin
                    state_next = (pending != '0) ? ON : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending update applies a new request and an ON-entry decrement together.
    always_comb begin
        entry        = (state_next != state);
        dec          = entry && (state_next == ON);
        add          = trig ? SUM_W'(count) : '0;
        sum          = SUM_W'(pending) + add - SUM_W'(dec);
        ovf_next     = (sum > SUM_W'(PEND_MAX));
        pending_next = ovf_next ? PEND_MAX : sum[PEND_W-1:0];
        led_next     = (state_next == ON);
        done_next    = (state == OFF) && (state_next == IDLE);
        phase_next   = phase;
        if (entry) begin
            phase_next = '0;
        end else if (tick_c) begin
            phase_next = phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            phase   <= '0;
            led     <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            pending <= pending_next;
            phase   <= phase_next;
            led     <= led_next;
            done    <= done_next;
            ovf     <= ovf_next;
        end
    end

    assign busy = (state != IDLE) || (pending != '0);

endmodule
